// File: rtl/stopwatch_ctrl.sv
// Stopwatch control: sync/debounce/edge-detect buttons, STOP/RUN/CLEAR FSM.
// Optional lap-hold path enabled by defining STOPWATCH_LAP_EN.
module stopwatch_btn #(
    parameter int DB_CYCLES = 1_000_000
) (
    input  logic clk,
    input  logic reset,
    input  logic raw,
    output logic pulse
);
    localparam int CW = $clog2(DB_CYCLES);

    logic          s1, s2, db, db_d;
    logic [CW-1:0] cnt;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            s1   <= 1'b0;
            s2   <= 1'b0;
            db   <= 1'b0;
            db_d <= 1'b0;
            cnt  <= '0;
        end else begin
            s1   <= raw;
            s2   <= s1;
            db_d <= db;
            if (s2 == db) begin
                cnt <= '0;
            end else if (cnt == CW'(DB_CYCLES - 1)) begin
                db  <= s2;
                cnt <= '0;
            end else begin
                cnt <= cnt + CW'(1);
            end
        end
    end

    assign pulse = db & ~db_d;
endmodule

module stopwatch_ctrl #(
    parameter int DB_CYCLES = 1_000_000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       i_btn_run_stop,
    input  logic       i_btn_clear,
    input  logic       i_btn_lap,
    output logic       o_run_on,
    output logic       o_clr_on,
    output logic [1:0] o_state,
    output logic       o_lap_hold
);
    typedef enum logic [1:0] {
        ST_STOP  = 2'd0,
        ST_RUN   = 2'd1,
        ST_CLEAR = 2'd2
    } state_t;

    state_t state, state_n;
    logic   run_p, clr_p;

    stopwatch_btn #(.DB_CYCLES(DB_CYCLES)) u_run (
        .clk   (clk),
        .reset (reset),
        .raw   (i_btn_run_stop),
        .pulse (run_p)
    );

    stopwatch_btn #(.DB_CYCLES(DB_CYCLES)) u_clr (
        .clk   (clk),
        .reset (reset),
        .raw   (i_btn_clear),
        .pulse (clr_p)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= ST_STOP;
        else       state <= state_n;
    end

    // Clear has priority over run in STOP; the run press is dropped.
    always_comb begin
        state_n = state;
        case (state)
            ST_STOP: begin
                if (clr_p)      state_n = ST_CLEAR;
                else if (run_p) state_n = ST_RUN;
            end
            ST_RUN: begin
                if (run_p) state_n = ST_STOP;
            end
            ST_CLEAR: state_n = ST_STOP;
            default:  state_n = ST_STOP;
        endcase
    end

    assign o_run_on = (state == ST_RUN);
    assign o_clr_on = (state == ST_CLEAR);
    assign o_state  = state;

`ifdef STOPWATCH_LAP_EN
    logic lap_p, lap_hold;

    stopwatch_btn #(.DB_CYCLES(DB_CYCLES)) u_lap (
        .clk   (clk),
        .reset (reset),
        .raw   (i_btn_lap),
        .pulse (lap_p)
    );

    // Toggle only while staying in RUN; leaving RUN drops the hold.
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            lap_hold <= 1'b0;
        else if (state == ST_RUN && state_n == ST_RUN)
            lap_hold <= lap_hold ^ lap_p;
        else
            lap_hold <= 1'b0;
    end

    assign o_lap_hold = lap_hold;
`else
    logic unused_lap;
    assign unused_lap = i_btn_lap;
    assign o_lap_hold = 1'b0;
`endif
endmodule
